// File: rtl/kbd_event_fifo.sv
// PS/2 scan-code parser feeding a show-ahead event FIFO, with modifier
// tracking, typematic repeat tagging and a fixed-length STOP pulse.
module kbd_event_fifo #(
    parameter int DEPTH        = 8,
    parameter bit PASS_REPEAT  = 1'b1,
    parameter bit QUEUE_BREAKS = 1'b0,
    parameter int PULSE_LEN    = 256
) (
    input  logic                     mclk,
    input  logic                     reset_in,
    input  logic                     scan_dav,
    input  logic [7:0]               scan_code,
    input  logic                     rd,
    output logic                     evt_valid,
    output logic [7:0]               evt_code,
    output logic                     evt_e0,
    output logic                     evt_brk,
    output logic                     evt_rpt,
    output logic [2:0]               evt_mods,
    output logic [2:0]               mods,
    output logic                     key_stop,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 14;
    localparam logic [AW:0] FULL_LVL  = DEPTH[AW:0];
    localparam logic [15:0] PULSE_CNT = PULSE_LEN[15:0];

    logic          e0f, brkf;
    logic [2:0]    skip_cnt;
    logic          held_vld;
    logic [8:0]    held_key;
    logic [15:0]   stop_cnt;
    logic          pend_vld;
    logic [EW-1:0] pend_ent;

    logic          skip_busy, is_filler, evt_done;
    logic [8:0]    key_id;
    logic          fake_shift, is_shift, is_ctrl, is_alt, is_mod, is_f12;
    logic          is_rep, do_queue, stop_start;

    assign skip_busy  = skip_cnt != 3'd0;
    assign is_filler  = scan_code inside {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};
    assign evt_done   = scan_dav && !skip_busy
                        && !(scan_code inside {8'hE1, 8'hE0, 8'hF0})
                        && !(is_filler && !e0f && !brkf);
    assign key_id     = {e0f, scan_code};
    assign fake_shift = e0f && (scan_code == 8'h12);
    assign is_shift   = !e0f && ((scan_code == 8'h12) || (scan_code == 8'h59));
    assign is_ctrl    = scan_code == 8'h14;
    assign is_alt     = scan_code == 8'h11;
    assign is_mod     = is_shift || is_ctrl || is_alt;
    assign is_f12     = !e0f && (scan_code == 8'h07);
    assign is_rep     = !brkf && held_vld && (held_key == key_id);
    assign do_queue   = evt_done && !fake_shift && !is_mod && !is_f12
                        && (brkf ? QUEUE_BREAKS : (!is_rep || PASS_REPEAT));
    assign stop_start = evt_done && is_f12 && !brkf && (stop_cnt == 16'd0);

    always_ff @(posedge mclk) begin
        if (reset_in) begin
            e0f      <= 1'b0;
            brkf     <= 1'b0;
            skip_cnt <= 3'd0;
            held_vld <= 1'b0;
            held_key <= 9'd0;
            mods     <= 3'd0;
        end else if (scan_dav) begin
            if (skip_busy) begin
                skip_cnt <= skip_cnt - 3'd1;
            end else if (scan_code == 8'hE1) begin
                // Pause sends E1 plus seven more bytes with no break
                skip_cnt <= 3'd7;
                e0f      <= 1'b0;
                brkf     <= 1'b0;
            end else if (scan_code == 8'hE0) begin
                e0f <= 1'b1;
            end else if (scan_code == 8'hF0) begin
                brkf <= 1'b1;
            end else if (evt_done) begin
                e0f  <= 1'b0;
                brkf <= 1'b0;
                if (!fake_shift) begin
                    if (!brkf && !is_rep) begin
                        held_vld <= 1'b1;
                        held_key <= key_id;
                    end else if (brkf && held_vld && (held_key == key_id)) begin
                        held_vld <= 1'b0;
                    end
                    if (is_shift) mods[0] <= !brkf;
                    if (is_ctrl)  mods[1] <= !brkf;
                    if (is_alt)   mods[2] <= !brkf;
                end
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (reset_in) begin
            pend_vld <= 1'b0;
            pend_ent <= '0;
            stop_cnt <= 16'd0;
        end else begin
            pend_vld <= do_queue;
            if (do_queue) pend_ent <= {mods, is_rep, brkf, e0f, scan_code};
            if (stop_start) stop_cnt <= PULSE_CNT;
            else if (stop_cnt != 16'd0) stop_cnt <= stop_cnt - 16'd1;
        end
    end

    assign key_stop = stop_cnt != 16'd0;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] head_hold, head;
    logic          fifo_full, do_pop, do_wr, ovf_set;

    assign evt_valid = level != '0;
    assign fifo_full = level == FULL_LVL;
    assign do_pop    = rd && evt_valid;
    assign do_wr     = pend_vld && (!fifo_full || do_pop);
    assign ovf_set   = pend_vld && fifo_full && !do_pop;

    always_ff @(posedge mclk) begin
        if (do_wr) mem[wr_ptr] <= pend_ent;
    end

    always_ff @(posedge mclk) begin
        if (reset_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            head_hold <= '0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            if (evt_valid) head_hold <= mem[rd_ptr];
        end
    end

    // an empty FIFO keeps presenting the last head seen
    assign head = evt_valid ? mem[rd_ptr] : head_hold;
    assign {evt_mods, evt_rpt, evt_brk, evt_e0, evt_code} = head;

endmodule

// File: doc/kbd_event_fifo.md
Name: kbd_event_fifo

Overview:
- Parametrised successor to the BK keyboard front end.
- Parses the raw PS/2 byte stream from PS2_Ctrl (Scan_DAV/Scan_Code) into make/break key events with E0 qualification, and tracks shift/ctrl/alt.
- Tags typematic repeats and queues events in a show-ahead FIFO, so the CPU-side translator no longer loses keys between reads.
- Generates a fixed-length STOP pulse.

Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..64.
- PASS_REPEAT, 1: 1 = queue typematic repeat makes with evt_rpt=1; 0 = drop them.
- QUEUE_BREAKS, 0: 1 = queue break events; 0 = queue makes only.
- PULSE_LEN, 256: key_stop pulse length in mclk cycles; 1..65535.

Ports:
- mclk  in  1  system clock
- reset_in  in  1  synchronous, active-high reset
- scan_dav  in  1  one-cycle strobe: scan_code valid
- scan_code  in  8  PS/2 byte
- rd  in  1  pop head entry; ignored when evt_valid=0
- evt_valid  out  1  FIFO non-empty
- evt_code  out  8  head entry scan code
- evt_e0  out  1  head entry had E0 prefix
- evt_brk  out  1  head entry is a break
- evt_rpt  out  1  head entry is a typematic repeat
- evt_mods  out  3  {alt,ctrl,shift} at the time the head entry was written
- mods  out  3  live {alt,ctrl,shift}
- key_stop  out  1  STOP pulse
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full
- ovf_clr  in  1  clears overflow
- level  out  clog2(DEPTH)+1  entry count

Behaviour:
- Reset: synchronous, wins over all inputs. Clears:
  - all outputs to 0 (level=0, evt_valid=0, mods=0, key_stop=0, overflow=0);
  - parser flags, held-key register, E1 skip counter, FIFO pointers and stop counter.
- Reset mid-sequence discards any partial prefix.
- Bytes are sampled only on edges where scan_dav=1.
- Parser:
  - Flags: e0f and brkf.
  - E1 skip counter: while non-zero, each sampled byte is dropped and the counter decrements.
  - 0xE1 with counter=0: load 7, clear flags. This swallows the 8-byte Pause sequence.
  - 0xE0: e0f<=1.
  - 0xF0: brkf<=1.
  - 0xAA, 0xFA, 0xFE, 0x00, 0xFF with both flags clear: dropped (BAT/ack/resend/error).
  - Any other byte completes event {brkf,e0f,code}; both flags clear on the same edge.
- Modifiers (not queued):
  - code 0x12 or 0x59 without E0 → shift;
  - 0x14 with or without E0 → ctrl;
  - 0x11 with or without E0 → alt.
  - Make sets, break clears; mods updates on the completing edge.
  - E0 0x12 (fake shift) is dropped entirely.
- STOP:
  - F12 make (0x07, no E0) is not queued.
  - If the counter is idle, key_stop goes high the cycle after sampling and stays high exactly PULSE_LEN cycles.
  - F12 makes while the pulse is active are ignored.
  - F12 break is dropped.
- Held key:
  - A make whose {e0,code} equals the held register is a repeat: evt_rpt=1, queued only if PASS_REPEAT=1.
  - Any non-repeat make loads the held register.
  - A break matching the held key clears it; other breaks leave it.
- Queueable event: non-modifier, non-STOP make (subject to repeat rule), or break if QUEUE_BREAKS=1. The entry is {evt_mods snapshot, rpt, brk, e0, code}.
- Latency: the final byte is sampled at edge k; the entry is written at edge k+1; evt_valid and head outputs are valid after edge k+1. An empty FIFO shows the new entry as head immediately (show-ahead).
- FIFO:
  - Pop on rd&evt_valid; the head advances after that edge.
  - Write when full with no pop: the event is dropped, overflow<=1, contents unchanged.
  - Write and pop on the same edge when full: both happen, level unchanged, no overflow.
  - Same on an empty FIFO: the pop is ignored, the write happens.
  - Pointers wrap modulo DEPTH.
  - level = writes minus pops, range 0..DEPTH.
- Overflow: ovf_clr clears it. If ovf_clr and a new overflow occur on the same edge, the set wins.
- Head outputs hold their last value when empty; only evt_valid is meaningful then.

Test Plan:
- Reset, then bytes 1C, F0 1C (QUEUE_BREAKS=0) → one entry {code=1C,e0=0,brk=0,rpt=0,mods=0}; evt_valid high 1 cycle after the 1C strobe; level=1; after rd, level=0.
- 12, 1C, 1C, F0 1C, F0 12 with PASS_REPEAT=1 → two entries, both evt_mods=001, second evt_rpt=1; mods returns to 000. With PASS_REPEAT=0 → one entry.
- E0 75, then E1 14 77 E1 F0 14 F0 77, then FA → exactly one entry {75,e0=1}; skip counter reaches 0; FA dropped; mods stays 000.
- DEPTH=4: nine distinct makes with no rd → level=4, overflow=1; first four codes read back in order; ovf_clr clears overflow.
- Full FIFO, rd asserted on the same edge a new event is written → level stays 4, overflow stays 0, new code appears last.
- 07 with PULSE_LEN=16 → key_stop high exactly 16 cycles; second 07 inside the pulse does not extend it; FIFO empty. reset_in during the pulse → key_stop low on the next edge.
